// File: rtl/hazard_unit.sv
// Hazard scoreboard and forwarding selector for the five-stage MIPS core.
// Define HAZARD_FWD_EN for full forwarding; otherwise selects tie to 0 and any in-flight E/M writer stalls.
module hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic [4:0]             d_rs,
  input  logic [4:0]             d_rt,
  input  logic [2:0]             d_tuse_rs,
  input  logic [2:0]             d_tuse_rt,
  input  logic [2:0]             d_tnew,
  input  logic [4:0]             d_dst,
  output logic                   stall,
  output logic [1:0]             d_fwd_rs,
  output logic [1:0]             d_fwd_rt,
  output logic [1:0]             e_fwd_rs,
  output logic [1:0]             e_fwd_rt,
  output logic                   m_fwd_rt,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [4:0] dst;
    logic [2:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } entry_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  entry_t                 e_q, m_q, w_q;
  entry_t                 e_d, m_d, w_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   rs_block, rt_block;
  logic                   unused_state;

  function automatic logic [2:0] sat0_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] cnt_sat_inc(input logic [STALL_CNT_W-1:0] c,
                                                         input logic inc);
    return (inc && (c != '1)) ? c + CNT_ONE : c;
  endfunction

  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (dst == src);
  endfunction

`ifdef HAZARD_FWD_EN
  // The youngest matching producer decides; a not-ready one blocks older stages.
  function automatic logic [1:0] d_select(input logic [4:0] src,
                                          input logic [4:0] e_dst, input logic [2:0] e_tnew,
                                          input logic [4:0] m_dst, input logic [2:0] m_tnew,
                                          input logic [4:0] w_dst);
    if (reg_match(src, e_dst)) return (e_tnew == 3'd0) ? 2'd1 : 2'd0;
    if (reg_match(src, m_dst)) return (m_tnew == 3'd0) ? 2'd2 : 2'd0;
    if (reg_match(src, w_dst)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_select(input logic [4:0] src,
                                          input logic [4:0] m_dst, input logic [2:0] m_tnew,
                                          input logic [4:0] w_dst);
    if (reg_match(src, m_dst)) return (m_tnew == 3'd0) ? 2'd1 : 2'd0;
    if (reg_match(src, w_dst)) return 2'd2;
    return 2'd0;
  endfunction
`endif

  always_comb begin
    rs_block = 1'b0;
    rt_block = 1'b0;
`ifdef HAZARD_FWD_EN
    rs_block = (reg_match(d_rs, e_q.dst) && (e_q.tnew > d_tuse_rs)) ||
               (reg_match(d_rs, m_q.dst) && (m_q.tnew > d_tuse_rs));
    rt_block = (reg_match(d_rt, e_q.dst) && (e_q.tnew > d_tuse_rt)) ||
               (reg_match(d_rt, m_q.dst) && (m_q.tnew > d_tuse_rt));
`else
    rs_block = reg_match(d_rs, e_q.dst) || reg_match(d_rs, m_q.dst);
    rt_block = reg_match(d_rt, e_q.dst) || reg_match(d_rt, m_q.dst);
`endif
    stall = d_valid && (((d_tuse_rs < 3'd4) && rs_block) ||
                        ((d_tuse_rt < 3'd4) && rt_block));
  end

  always_comb begin
    d_fwd_rs = 2'd0;
    d_fwd_rt = 2'd0;
    e_fwd_rs = 2'd0;
    e_fwd_rt = 2'd0;
    m_fwd_rt = 1'b0;
`ifdef HAZARD_FWD_EN
    d_fwd_rs = d_select(d_rs, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew, w_q.dst);
    d_fwd_rt = d_select(d_rt, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew, w_q.dst);
    e_fwd_rs = e_select(e_q.rs, m_q.dst, m_q.tnew, w_q.dst);
    e_fwd_rt = e_select(e_q.rt, m_q.dst, m_q.tnew, w_q.dst);
    m_fwd_rt = reg_match(m_q.rt, w_q.dst);
`endif
  end

  // Shadow pipeline advance: M and W always move, E takes a bubble on stall.
  always_comb begin
    w_d      = m_q;
    w_d.tnew = 3'd0;
    m_d      = e_q;
    m_d.tnew = sat0_dec(e_q.tnew);
    e_d      = '0;
    if (d_valid && !stall) begin
      e_d.dst  = d_dst;
      e_d.tnew = sat0_dec(d_tnew);
      e_d.rs   = d_rs;
      e_d.rt   = d_rt;
    end
    cnt_d = cnt_sat_inc(cnt_q, stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  // Some entry fields are only consumed in one build configuration.
  assign unused_state = ^{e_q, m_q, w_q};
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed MIPS sequences plus randomized traffic
// against an in-flight-instruction model; follows HAZARD_FWD_EN like the design.
module tb_hazard_unit;

  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid;
  logic [4:0]    d_rs, d_rt, d_dst;
  logic [2:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic          stall;
  logic [1:0]    d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;
  logic          m_fwd_rt;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_unit #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_tnew(d_tnew), .d_dst(d_dst), .stall(stall),
    .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt), .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt),
    .m_fwd_rt(m_fwd_rt), .stall_count(stall_count)
  );

  // Model: instructions that left D, by age (index 0 = one cycle after D, i.e. in E).
  typedef struct {int dst; int tnew; int rs; int rt;} ins_t;
  ins_t pipe[3];
  int   m_count;
  int   checks = 0;
  int   errors = 0;
  bit   exp_stall;
  int   exp_dfrs, exp_dfrt, exp_efrs, exp_efrt, exp_mfrt;

  function automatic int rem(int t, int age);
    return (t - age > 0) ? t - age : 0;
  endfunction

  function automatic bit m_src_stall(int s, int tuse);
    if (s == 0 || tuse >= 4) return 1'b0;
    for (int a = 1; a <= 2; a++) begin
      if (pipe[a-1].dst == s) begin
`ifdef HAZARD_FWD_EN
        if (rem(pipe[a-1].tnew, a) > tuse) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_d_sel(int s);
    if (!FWD || s == 0) return 0;
    for (int a = 1; a <= 3; a++) begin
      if (pipe[a-1].dst == s) begin
        if (a == 3) return 3;
        return (rem(pipe[a-1].tnew, a) == 0) ? a : 0;
      end
    end
    return 0;
  endfunction

  function automatic int m_e_sel(int s);
    if (!FWD || s == 0) return 0;
    if (pipe[1].dst == s) return (rem(pipe[1].tnew, 2) == 0) ? 1 : 0;
    if (pipe[2].dst == s) return 2;
    return 0;
  endfunction

  task automatic eval_model();
    exp_stall = d_valid && (m_src_stall(int'(d_rs), int'(d_tuse_rs)) ||
                            m_src_stall(int'(d_rt), int'(d_tuse_rt)));
    exp_dfrs  = m_d_sel(int'(d_rs));
    exp_dfrt  = m_d_sel(int'(d_rt));
    exp_efrs  = m_e_sel(pipe[0].rs);
    exp_efrt  = m_e_sel(pipe[0].rt);
    exp_mfrt  = (FWD && pipe[1].rt != 0 && pipe[2].dst == pipe[1].rt) ? 1 : 0;
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input int tur,
                       input int tut, input int tnew, input int dst);
    d_valid   = v;
    d_rs      = 5'(rs);
    d_rt      = 5'(rt);
    d_tuse_rs = 3'(tur);
    d_tuse_rt = 3'(tut);
    d_tnew    = 3'(tnew);
    d_dst     = 5'(dst);
    eval_model();
  endtask

  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
      m_count = 0;
    end else begin
      if (exp_stall && m_count < MAXC) m_count++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (exp_stall || !d_valid) pipe[0] = '{0, 0, 0, 0};
      else pipe[0] = '{int'(d_dst), int'(d_tnew), int'(d_rs), int'(d_rt)};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    tick();
    reset = 1'b0;
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
  endtask

  // Present an instruction in D, holding it while the model stalls; returns at the
  // negedge of its issuing cycle with the number of cycles the DUT flagged stall.
  task automatic issue(input int rs, input int rt, input int tur, input int tut,
                       input int tnew, input int dst, output int nst);
    nst = 0;
    for (int k = 0; k < 12; k++) begin
      set_d(1'b1, rs, rt, tur, tut, tnew, dst);
      @(negedge clk);
      if (!exp_stall) return;
      if (stall === 1'b1) nst++;
      tick();
    end
    errors++;
    $display("FAIL issue_timeout: stall still expected after 12 cycles, required release");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(1'b1, 3, 4, 0, 0, 3, 5);
    tick();
    tick();
    reset = 1'b0;
    set_d(1'b1, 3, 4, 0, 0, 3, 5);
    @(negedge clk);
    checks += 7;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    if (d_fwd_rs !== 2'd0) begin errors++; $display("FAIL reset_dfrs: got %0d want 0", d_fwd_rs); end
    if (d_fwd_rt !== 2'd0) begin errors++; $display("FAIL reset_dfrt: got %0d want 0", d_fwd_rt); end
    if (e_fwd_rs !== 2'd0) begin errors++; $display("FAIL reset_efrs: got %0d want 0", e_fwd_rs); end
    if (e_fwd_rt !== 2'd0) begin errors++; $display("FAIL reset_efrt: got %0d want 0", e_fwd_rt); end
    if (m_fwd_rt !== 1'b0) begin errors++; $display("FAIL reset_mfrt: got %b want 0", m_fwd_rt); end
    if (stall_count !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
    tick();
  endtask

  task automatic test_alu_fwd();
    int n;
    do_reset();
    issue(1, 2, 1, 1, 2, 3, n);   // addu $3,$1,$2
    tick();
    issue(3, 3, 1, 1, 2, 4, n);   // subu $4,$3,$3
    checks += 3;
    if (n != (FWD ? 0 : 2)) begin errors++; $display("FAIL alu_stalls: got %0d want %0d", n, FWD ? 0 : 2); end
    tick();
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    @(negedge clk);
    if (e_fwd_rs !== 2'(FWD ? 1 : 0)) begin errors++; $display("FAIL alu_efrs: got %0d want %0d", e_fwd_rs, FWD ? 1 : 0); end
    if (e_fwd_rt !== 2'(FWD ? 1 : 0)) begin errors++; $display("FAIL alu_efrt: got %0d want %0d", e_fwd_rt, FWD ? 1 : 0); end
    tick();
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    issue(0, 5, 1, 7, 3, 5, n);   // lw $5,0($0)
    tick();
    issue(5, 0, 1, 1, 2, 6, n);   // addu $6,$5,$0
    checks += 4;
    if (n != (FWD ? 1 : 2)) begin errors++; $display("FAIL lu_stalls: got %0d want %0d", n, FWD ? 1 : 2); end
    if (d_fwd_rs !== 2'd0) begin errors++; $display("FAIL lu_dfrs: got %0d want 0", d_fwd_rs); end
    tick();
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    @(negedge clk);
    if (e_fwd_rs !== 2'(exp_efrs)) begin errors++; $display("FAIL lu_efrs: got %0d want %0d", e_fwd_rs, exp_efrs); end
    if (stall_count !== CW'(FWD ? 1 : 2)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_count, FWD ? 1 : 2); end
    tick();
  endtask

  task automatic test_branch();
    int n;
    do_reset();
    issue(0, 7, 1, 7, 3, 7, n);   // lw $7
    tick();
    issue(7, 0, 0, 0, 0, 0, n);   // beq $7,$0
    checks += 3;
    if (n != 2) begin errors++; $display("FAIL lb_stalls: got %0d want 2", n); end
    if (d_fwd_rs !== 2'(FWD ? 3 : 0)) begin errors++; $display("FAIL lb_dfrs: got %0d want %0d", d_fwd_rs, FWD ? 3 : 0); end
    if (stall_count !== CW'(2)) begin errors++; $display("FAIL lb_cnt: got %0d want 2", stall_count); end
    tick();
    do_reset();
    issue(1, 2, 1, 1, 2, 8, n);   // addu $8,$1,$2
    tick();
    issue(8, 0, 0, 0, 0, 0, n);   // beq $8,$0
    checks += 2;
    if (n != (FWD ? 1 : 2)) begin errors++; $display("FAIL ab_stalls: got %0d want %0d", n, FWD ? 1 : 2); end
    if (d_fwd_rs !== 2'(FWD ? 2 : 0)) begin errors++; $display("FAIL ab_dfrs: got %0d want %0d", d_fwd_rs, FWD ? 2 : 0); end
    tick();
  endtask

  task automatic test_jal_jr();
    int n;
    do_reset();
    issue(0, 0, 7, 7, 0, 31, n);  // jal
    tick();
    issue(31, 0, 0, 7, 0, 0, n);  // jr $31
    checks += 2;
    if (n != (FWD ? 0 : 2)) begin errors++; $display("FAIL jr_stalls: got %0d want %0d", n, FWD ? 0 : 2); end
    if (d_fwd_rs !== 2'(FWD ? 1 : 0)) begin errors++; $display("FAIL jr_dfrs: got %0d want %0d", d_fwd_rs, FWD ? 1 : 0); end
    tick();
  endtask

  task automatic test_zero_reg();
    int n;
    do_reset();
    issue(0, 0, 1, 7, 2, 0, n);   // ori $0,$0,1
    tick();
    issue(0, 0, 1, 1, 2, 1, n);   // addu $1,$0,$0
    checks += 6;
    if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
    if (d_fwd_rs !== 2'd0) begin errors++; $display("FAIL zero_dfrs: got %0d want 0", d_fwd_rs); end
    if (d_fwd_rt !== 2'd0) begin errors++; $display("FAIL zero_dfrt: got %0d want 0", d_fwd_rt); end
    tick();
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    @(negedge clk);
    if (e_fwd_rs !== 2'd0) begin errors++; $display("FAIL zero_efrs: got %0d want 0", e_fwd_rs); end
    if (e_fwd_rt !== 2'd0) begin errors++; $display("FAIL zero_efrt: got %0d want 0", e_fwd_rt); end
    if (m_fwd_rt !== 1'b0) begin errors++; $display("FAIL zero_mfrt: got %b want 0", m_fwd_rt); end
    tick();
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    for (int i = 0; i < MAXC / 2 + 4; i++) begin
      issue(1, 0, 0, 7, 7, 1, n);  // each one waits two cycles on its predecessor
      tick();
    end
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    @(negedge clk);
    checks += 1;
    if (stall_count !== CW'(MAXC)) begin errors++; $display("FAIL sat_cnt: got %0d want %0d", stall_count, MAXC); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    int n;
    do_reset();
    issue(0, 7, 1, 7, 3, 7, n);   // lw $7
    tick();
    set_d(1'b1, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 4;
    if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(1'b1, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_post: got %b want 0", stall); end
    if (stall_count !== '0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", stall_count); end
    if (d_fwd_rs !== 2'd0) begin errors++; $display("FAIL mid_dfrs: got %0d want 0", d_fwd_rs); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!exp_stall)
        set_d($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3));
      else
        eval_model();
      @(negedge clk);
      checks += 7;
      if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, exp_stall); end
      if (d_fwd_rs !== 2'(exp_dfrs)) begin errors++; $display("FAIL rnd_dfrs c%0d: got %0d want %0d", c, d_fwd_rs, exp_dfrs); end
      if (d_fwd_rt !== 2'(exp_dfrt)) begin errors++; $display("FAIL rnd_dfrt c%0d: got %0d want %0d", c, d_fwd_rt, exp_dfrt); end
      if (e_fwd_rs !== 2'(exp_efrs)) begin errors++; $display("FAIL rnd_efrs c%0d: got %0d want %0d", c, e_fwd_rs, exp_efrs); end
      if (e_fwd_rt !== 2'(exp_efrt)) begin errors++; $display("FAIL rnd_efrt c%0d: got %0d want %0d", c, e_fwd_rt, exp_efrt); end
      if (m_fwd_rt !== 1'(exp_mfrt)) begin errors++; $display("FAIL rnd_mfrt c%0d: got %b want %0d", c, m_fwd_rt, exp_mfrt); end
      if (stall_count !== CW'(m_count)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_count, m_count); end
      reset = ($urandom_range(0, 63) == 0);
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_count = 0;
    reset   = 1'b1;
    set_d(1'b0, 0, 0, 7, 7, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_jal_jr();
    test_zero_reg();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
